spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter_if.sv | 34 +++
 rtl/spi_arbiter.sv | 169 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// Bundle of request/response and SPI-master-facing signals of the SPI arbiter.
// The slave modport is the arbiter side. The master modport is the side that drives it.
interface spi_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [2*NREQ-1:0] req_mode;
    logic [8*NREQ-1:0] req_br;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [2:0]        rsp_id;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic [7:0]        data_m;
    logic [7:0]        spcon;
    logic [7:0]        spibr;
    logic [7:0]        spssn;
    logic [7:0]        data_r_m;
    logic              tr_done;
    logic              busy;

    modport slave (
        input  req, req_data, req_mode, req_br, data_r_m, tr_done,
        output gnt, rsp_valid, rsp_id, rsp_data, rsp_err,
               data_m, spcon, spibr, spssn, busy
    );

    modport master (
        output req, req_data, req_mode, req_br, data_r_m, tr_done,
        input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err,
               data_m, spcon, spibr, spssn, busy
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI master among NREQ requesters.
// Each requester gets its own slave select, and each transfer has setup, hold and timeout framing.
module spi_arbiter #(
    parameter int NREQ      = 4,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic         clk,
    input  logic         rst,
    spi_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t      state, state_nxt;
    logic [11:0] cnt, cnt_nxt;
    logic [2:0]  rr_ptr, cur_id, win, win_hi, win_lo, ptr_nxt;
    logic        found, found_hi;
    logic [7:0]  sel_data, sel_br;
    logic [1:0]  sel_mode, mode_q;
    logic [7:0]  data_m_q, spibr_q, rsp_data_q;
    logic [2:0]  rsp_id_q;
    logic        rsp_err_q;
    logic        setup_last, hold_last, tmo, ssn_act;

    // Winner is the lowest requester at or above rr_ptr, else the lowest one overall (wrap).
    always_comb begin
        found    = 1'b0;
        found_hi = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                found  = 1'b1;
                win_lo = 3'(i);
                if (3'(i) >= rr_ptr) begin
                    found_hi = 1'b1;
                    win_hi   = 3'(i);
                end
            end
        end
        win     = found_hi ? win_hi : win_lo;
        ptr_nxt = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
    end

    always_comb begin
        sel_data = '0;
        sel_mode = '0;
        sel_br   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == 3'(i)) begin
                sel_data = bus.req_data[i*8 +: 8];
                sel_mode = bus.req_mode[i*2 +: 2];
                sel_br   = bus.req_br[i*8 +: 8];
            end
        end
    end

    assign setup_last = (cnt == 12'(SETUP_CYC - 1));
    assign hold_last  = (cnt == 12'(HOLD_CYC - 1));
    assign tmo        = (cnt == 12'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (found) state_nxt = SETUP;
            end
            SETUP: begin
                if (setup_last) begin
                    state_nxt = XFER;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 12'd1;
                end
            end
            XFER: begin
                if (bus.tr_done || tmo) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 12'd1;
                end
            end
            HOLD: begin
                if (hold_last) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 12'd1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Transfer parameters are frozen at the grant edge, so later req changes cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            cur_id     <= '0;
            data_m_q   <= '0;
            mode_q     <= '0;
            spibr_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            if (state == IDLE && found) begin
                rr_ptr   <= ptr_nxt;
                cur_id   <= win;
                data_m_q <= sel_data;
                mode_q   <= sel_mode;
                spibr_q  <= sel_br;
            end
            if (state == XFER) begin
                if (bus.tr_done) begin
                    rsp_data_q <= bus.data_r_m;
                    rsp_err_q  <= 1'b0;
                end else if (tmo) begin
                    rsp_data_q <= 8'h00;
                    rsp_err_q  <= 1'b1;
                end
            end
            if (state == HOLD && hold_last) rsp_id_q <= cur_id;
        end
    end

    assign ssn_act = (state == SETUP) || (state == XFER) || (state == HOLD);

    always_comb begin
        bus.gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.gnt[i] = !rst && found && (state == IDLE) && (win == 3'(i));
        end
        bus.spssn = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i < NREQ && ssn_act && cur_id == 3'(i)) bus.spssn[i] = 1'b0;
        end
    end

    assign bus.spcon     = {5'b0, mode_q, state == XFER};
    assign bus.spibr     = spibr_q;
    assign bus.data_m    = data_m_q;
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = (state == GAP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter.
// It covers a single transfer, spurious done pulses, timeout, the done/timeout collision, reset mid-transfer and round robin.
module tb_spi_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    spi_arbiter_if #(.NREQ(4)) bus ();

    spi_arbiter #(
        .NREQ(4), .SETUP_CYC(2), .HOLD_CYC(2), .TIMEOUT(4095)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer from a visible grant to the return to IDLE, answering with rdata.
    task automatic do_xfer(input logic [7:0] rdata, input logic drop, output logic [3:0] g);
        g = bus.gnt;
        tick();
        if (drop) bus.req = 4'b0000;
        tick();
        tick();
        bus.tr_done  = 1'b1;
        bus.data_r_m = rdata;
        tick();
        bus.tr_done = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        logic [3:0] g;
        int         n;
        logic       any_valid;

        bus.req      = '0;
        bus.req_data = '0;
        bus.req_mode = '0;
        bus.req_br   = '0;
        bus.data_r_m = '0;
        bus.tr_done  = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_spssn", bus.spssn, 8'hFF);
        chk("rst_spcon", bus.spcon, 8'h00);
        chk("rst_spibr", bus.spibr, 8'h00);
        chk("rst_data_m", bus.data_m, 8'h00);
        chk("rst_gnt", bus.gnt, 4'b0000);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        chk("rst_rsp_id", bus.rsp_id, 3'd0);
        chk("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;

        // Single transfer for requester 1, with spurious done pulses in SETUP and HOLD
        bus.req_data[15:8] = 8'hA5;
        bus.req_mode[3:2]  = 2'b01;
        bus.req_br[15:8]   = 8'h12;
        bus.req            = 4'b0010;
        #1;
        chk("single_gnt", bus.gnt, 4'b0010);
        tick();
        bus.req = 4'b0000;
        #1;
        chk("single_gnt_pulse", bus.gnt, 4'b0000);
        chk("setup_spssn", bus.spssn, 8'hFD);
        chk("setup_spcon", bus.spcon, 8'h02);
        chk("setup_busy", bus.busy, 1'b1);
        bus.tr_done  = 1'b1;
        bus.data_r_m = 8'hEE;
        tick();
        bus.tr_done = 1'b0;
        chk("setup2_spcon", bus.spcon, 8'h02);
        chk("setup2_spssn", bus.spssn, 8'hFD);
        tick();
        chk("xfer_spcon", bus.spcon, 8'h03);
        chk("xfer_spibr", bus.spibr, 8'h12);
        chk("xfer_data_m", bus.data_m, 8'hA5);
        chk("xfer_spssn", bus.spssn, 8'hFD);
        bus.tr_done  = 1'b1;
        bus.data_r_m = 8'h3C;
        tick();
        bus.tr_done = 1'b0;
        chk("hold_spcon", bus.spcon, 8'h02);
        chk("hold_spssn", bus.spssn, 8'hFD);
        chk("hold_rsp_valid", bus.rsp_valid, 1'b0);
        bus.tr_done  = 1'b1;
        bus.data_r_m = 8'hFF;
        tick();
        bus.tr_done = 1'b0;
        chk("hold2_spssn", bus.spssn, 8'hFD);
        chk("hold2_rsp_valid", bus.rsp_valid, 1'b0);
        tick();
        chk("gap_rsp_valid", bus.rsp_valid, 1'b1);
        chk("gap_rsp_id", bus.rsp_id, 3'd1);
        chk("gap_rsp_data", bus.rsp_data, 8'h3C);
        chk("gap_rsp_err", bus.rsp_err, 1'b0);
        chk("gap_spssn", bus.spssn, 8'hFF);
        chk("gap_spcon", bus.spcon, 8'h02);
        tick();
        chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_rsp_data_hold", bus.rsp_data, 8'h3C);

        // Spurious done pulse in IDLE
        bus.tr_done = 1'b1;
        tick();
        bus.tr_done = 1'b0;
        chk("idle_done_busy", bus.busy, 1'b0);
        tick();
        chk("idle_done_rsp_valid", bus.rsp_valid, 1'b0);

        // Timeout on requester 2
        bus.req_data[23:16] = 8'hC3;
        bus.req_mode[5:4]   = 2'b10;
        bus.req_br[23:16]   = 8'h34;
        bus.req             = 4'b0100;
        #1;
        chk("tmo_gnt", bus.gnt, 4'b0100);
        tick();
        bus.req = 4'b0000;
        tick();
        tick();
        chk("tmo_xfer_spcon", bus.spcon, 8'h05);
        n = 0;
        while (bus.spcon[0] && n < 5000) begin
            tick();
            n++;
        end
        chk("tmo_xfer_len", n, 4095);
        chk("tmo_rsp_err", bus.rsp_err, 1'b1);
        chk("tmo_rsp_data", bus.rsp_data, 8'h00);
        tick();
        tick();
        chk("tmo_gap_valid", bus.rsp_valid, 1'b1);
        chk("tmo_gap_id", bus.rsp_id, 3'd2);
        chk("tmo_gap_err", bus.rsp_err, 1'b1);
        tick();

        // A request following the timeout is still served
        bus.req_data[31:24] = 8'h11;
        bus.req_br[31:24]   = 8'h01;
        bus.req             = 4'b1000;
        #1;
        do_xfer(8'h77, 1'b1, g);
        chk("after_tmo_gnt", g, 4'b1000);
        chk("after_tmo_rsp_data", bus.rsp_data, 8'h77);
        chk("after_tmo_rsp_err", bus.rsp_err, 1'b0);
        chk("after_tmo_rsp_id", bus.rsp_id, 3'd3);

        // Done arriving on the last timeout cycle wins
        bus.req_data[7:0] = 8'h99;
        bus.req           = 4'b0001;
        #1;
        chk("coll_gnt", bus.gnt, 4'b0001);
        tick();
        bus.req = 4'b0000;
        tick();
        tick();
        repeat (4094) tick();
        chk("coll_still_xfer", bus.spcon[0], 1'b1);
        bus.tr_done  = 1'b1;
        bus.data_r_m = 8'h5A;
        tick();
        bus.tr_done = 1'b0;
        chk("coll_spcon_en", bus.spcon[0], 1'b0);
        chk("coll_rsp_err", bus.rsp_err, 1'b0);
        chk("coll_rsp_data", bus.rsp_data, 8'h5A);
        tick();
        tick();
        chk("coll_gap_valid", bus.rsp_valid, 1'b1);
        chk("coll_gap_err", bus.rsp_err, 1'b0);
        tick();

        // Reset mid-XFER: requester 2 is granted because rr_ptr is 1
        bus.req = 4'b0100;
        #1;
        chk("rstx_gnt", bus.gnt, 4'b0100);
        tick();
        bus.req = 4'b0000;
        tick();
        tick();
        chk("rstx_in_xfer", bus.spcon[0], 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("rstx_spssn", bus.spssn, 8'hFF);
        chk("rstx_spcon", bus.spcon, 8'h00);
        chk("rstx_busy", bus.busy, 1'b0);
        tick();
        rst = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            any_valid = any_valid | bus.rsp_valid;
        end
        chk("rstx_no_rsp", any_valid, 1'b0);

        // Round robin with all requests held
        bus.req = 4'b1111;
        #1;
        chk("rr_first_after_rst", bus.gnt, 4'b0001);
        do_xfer(8'h01, 1'b0, g);
        chk("rr_gnt0", g, 4'b0001);
        do_xfer(8'h02, 1'b0, g);
        chk("rr_gnt1", g, 4'b0010);
        do_xfer(8'h03, 1'b0, g);
        chk("rr_gnt2", g, 4'b0100);
        do_xfer(8'h04, 1'b0, g);
        chk("rr_gnt3", g, 4'b1000);
        chk("rr_rsp_id3", bus.rsp_id, 3'd3);
        chk("rr_rsp_data3", bus.rsp_data, 8'h04);
        do_xfer(8'h05, 1'b1, g);
        chk("rr_gnt0_again", g, 4'b0001);
        chk("rr_final_busy", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
